// File: rtl/uart_rx_fifo.sv
// Receive-side frame FIFO behind a UART receiver: edge-captures {err, data} on rx_done, show-ahead valid/ready read.
// Optional macro UART_RX_FIFO_DROP_ERR_EN discards errored frames and ties rd_err low.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              rx_done,
    input  logic              rx_err,
    input  logic [7:0]        rx_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    output logic              rd_err,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_ovf,
    input  logic              flush
);

`ifdef UART_RX_FIFO_DROP_ERR_EN
    localparam int unsigned ENTRY_W = 8;
`else
    localparam int unsigned ENTRY_W = 9;
`endif

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic               done_q;
    logic               wr_req;
    logic               wr_req_ok;
    logic               pop;
    logic               wr_en;
    logic               ovf_set;

    assign wr_req = rx_done & ~done_q;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    assign wr_req_ok = wr_req & ~rx_err;
    assign wr_entry  = rx_data;
    assign rd_data   = head;
    assign rd_err    = 1'b0;
`else
    assign wr_req_ok = wr_req;
    assign wr_entry  = {rx_err, rx_data};
    assign rd_data   = head[7:0];
    assign rd_err    = head[8];
`endif

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign rd_valid = ~empty;
    assign head     = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted.
    assign pop     = rd_valid & rd_ready;
    assign wr_en   = wr_req_ok & (~full | pop) & ~flush;
    assign ovf_set = wr_req_ok & full & ~pop & ~flush;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            done_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done_q <= rx_done;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
                case ({wr_en, pop})
                    2'b10:   count <= count + (ADDR_W + 1)'(1);
                    2'b01:   count <= count - (ADDR_W + 1)'(1);
                    default: count <= count;
                endcase
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
